// File: rtl/data_ram.sv
// Purpose: word-addressed data RAM for the MEM stage, with self-clearing after reset, alignment/range checks and access counters.
// Latency: loads are combinational (same cycle); stores commit on the next rising clk edge.
// Backpressure: ready=0 while the clearing pass runs; requests are dropped, not stalled, until ready rises.
//
// Ports:
//   clk, rst               - clock and synchronous active-high reset
//   ram_read, ram_write    - load / store request from the MEM stage
//   ram_adr, ram_data      - byte address and store data
//   ram_word               - load data (0 when no accepted load)
//   ready                  - high once every word has been cleared
//   err_align, err_range   - sticky misaligned / out-of-range request flags
//   rd_count, wr_count     - saturating counts of accepted loads / stores
module data_ram #(
    parameter int DEPTH_LOG2 = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ram_read,
    input  logic             ram_write,
    input  logic [31:0]      ram_adr,
    input  logic [31:0]      ram_data,
    output logic [31:0]      ram_word,
    output logic             ready,
    output logic             err_align,
    output logic             err_range,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;
    localparam logic [CNT_W-1:0]      CNT_ONE = 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] clr_idx;
    logic [31:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  req;
    logic                  accept;
    logic                  rd_acc;
    logic                  wr_acc;

    assign word_idx     = ram_adr[DEPTH_LOG2+1:2];
    assign misaligned   = |ram_adr[1:0];
    assign out_of_range = |ram_adr[31:DEPTH_LOG2+2];
    assign req          = ram_read | ram_write;

    // ready is a registered copy of (state == RUN). rst is folded in so that
    // nothing is accepted or returned in the reset cycle itself, even before
    // the first edge has moved the FSM back to INIT.
    assign accept = ready & ~rst & ~misaligned & ~out_of_range;
    assign rd_acc = ram_read  & accept;
    assign wr_acc = ram_write & accept;

    // Read-before-write: a store in the same cycle only lands at the edge,
    // so the load sees the old contents.
    assign ram_word = rd_acc ? mem[word_idx] : 32'h0;

    // Storage has no reset of its own; the INIT pass clears it one word per
    // cycle. Nothing is written while rst is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[clr_idx] <= 32'h0;
            end else if (wr_acc) begin
                mem[word_idx] <= ram_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            clr_idx   <= '0;
            ready     <= 1'b0;
            err_align <= 1'b0;
            err_range <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            case (state)
                INIT: begin
                    clr_idx <= clr_idx + IDX_ONE;
                    if (clr_idx == {DEPTH_LOG2{1'b1}}) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    // Flags track requests, not accepted accesses, so a bad
                    // address is reported whether it was a load or a store.
                    if (req && misaligned) begin
                        err_align <= 1'b1;
                    end
                    if (req && out_of_range) begin
                        err_range <= 1'b1;
                    end
                    if (rd_acc && (rd_count != {CNT_W{1'b1}})) begin
                        rd_count <= rd_count + CNT_ONE;
                    end
                    if (wr_acc && (wr_count != {CNT_W{1'b1}})) begin
                        wr_count <= wr_count + CNT_ONE;
                    end
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram.sv
module tb_data_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_read;
    logic        ram_write;
    logic [31:0] ram_adr;
    logic [31:0] ram_data;

    logic [31:0] ram_word;
    logic        ready;
    logic        err_align;
    logic        err_range;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    logic [31:0] s_ram_word;
    logic        s_ready;
    logic        s_err_align;
    logic        s_err_range;
    logic [3:0]  s_rd_count;
    logic [3:0]  s_wr_count;

    int checks = 0;
    int errors = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    always #5 clk = ~clk;

    data_ram dut (
        .clk(clk), .rst(rst), .ram_read(ram_read), .ram_write(ram_write),
        .ram_adr(ram_adr), .ram_data(ram_data), .ram_word(ram_word),
        .ready(ready), .err_align(err_align), .err_range(err_range),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    data_ram #(.DEPTH_LOG2(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .ram_read(ram_read), .ram_write(ram_write),
        .ram_adr(ram_adr), .ram_data(ram_data), .ram_word(s_ram_word),
        .ready(s_ready), .err_align(s_err_align), .err_range(s_err_range),
        .rd_count(s_rd_count), .wr_count(s_wr_count)
    );

    // Apply a request at the falling edge; returns 1 time unit later so the
    // combinational load data can be sampled before the rising edge.
    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ram_read  = r;
        ram_write = w;
        ram_adr   = a;
        ram_data  = d;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic pulse_rst(input int n);
        @(negedge clk);
        ram_read  = 1'b0;
        ram_write = 1'b0;
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
    endtask

    // Counts rising edges until ready is seen high, bounded at 1000.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; ram_read = 1'b1; ram_write = 1'b1;
        ram_adr = 32'h0; ram_data = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++; if ({err_align, err_range} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {err_align, err_range}); end
        checks++; if ({rd_count, wr_count} !== 32'h0) begin errors++; $display("FAIL reset_counts: rd=%0d wr=%0d want 0 0", rd_count, wr_count); end
        checks++; if (ram_word !== 32'h0) begin errors++; $display("FAIL reset_word: got %h want 00000000", ram_word); end
        @(negedge clk);
        rst = 1'b0; ram_read = 1'b0; ram_write = 1'b0;
        exp_rd = 0; exp_wr = 0;
        wait_ready(n);
        checks++; if (n !== 256) begin errors++; $display("FAIL reset_init_len: got %0d cycles want 256", n); end
        drive(1'b1, 1'b0, 32'h0, 32'h0); exp_rd++;
        checks++; if (ram_word !== 32'h0) begin errors++; $display("FAIL reset_read0: got %h want 00000000", ram_word); end
        drive(1'b1, 1'b0, 32'h3FC, 32'h0); exp_rd++;
        checks++; if (ram_word !== 32'h0) begin errors++; $display("FAIL reset_read3fc: got %h want 00000000", ram_word); end
        idle_cycles(1);
        checks++; if (rd_count !== 16'(exp_rd)) begin errors++; $display("FAIL reset_rdcnt: got %0d want %0d", rd_count, exp_rd); end
    endtask

    task automatic test_store_load();
        drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF); exp_wr++;
        drive(1'b1, 1'b0, 32'h10, 32'h0); exp_rd++;
        checks++; if (ram_word !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_load: got %h want deadbeef", ram_word); end
        idle_cycles(1);
        checks++; if (wr_count !== 16'(exp_wr)) begin errors++; $display("FAIL store_load_wrcnt: got %0d want %0d", wr_count, exp_wr); end
        checks++; if (rd_count !== 16'(exp_rd)) begin errors++; $display("FAIL store_load_rdcnt: got %0d want %0d", rd_count, exp_rd); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 32'h20, 32'h1111_1111); exp_wr++;
        drive(1'b1, 1'b1, 32'h20, 32'h2222_2222); exp_wr++; exp_rd++;
        checks++; if (ram_word !== 32'h1111_1111) begin errors++; $display("FAIL rw_same_old: got %h want 11111111", ram_word); end
        drive(1'b1, 1'b0, 32'h20, 32'h0); exp_rd++;
        checks++; if (ram_word !== 32'h2222_2222) begin errors++; $display("FAIL rw_same_new: got %h want 22222222", ram_word); end
        idle_cycles(1);
        checks++; if (wr_count !== 16'(exp_wr)) begin errors++; $display("FAIL rw_same_wrcnt: got %0d want %0d", wr_count, exp_wr); end
        checks++; if (rd_count !== 16'(exp_rd)) begin errors++; $display("FAIL rw_same_rdcnt: got %0d want %0d", rd_count, exp_rd); end
    endtask

    task automatic test_errors();
        drive(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D); exp_wr++;
        drive(1'b0, 1'b1, 32'h12, 32'h0BAD_BAD0);
        checks++; if (err_align !== 1'b0) begin errors++; $display("FAIL err_align_early: got %b want 0", err_align); end
        drive(1'b1, 1'b0, 32'h400, 32'h0);
        checks++; if (ram_word !== 32'h0) begin errors++; $display("FAIL err_range_load: got %h want 00000000", ram_word); end
        checks++; if ({err_align, err_range} !== 2'b10) begin errors++; $display("FAIL err_align_set: got %b want 10", {err_align, err_range}); end
        drive(1'b0, 1'b1, 32'h400, 32'h9999_9999);
        checks++; if (err_range !== 1'b1) begin errors++; $display("FAIL err_range_set: got %b want 1", err_range); end
        drive(1'b1, 1'b0, 32'h402, 32'h0);
        checks++; if (ram_word !== 32'h0) begin errors++; $display("FAIL err_misaligned_load: got %h want 00000000", ram_word); end
        idle_cycles(1);
        checks++; if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin errors++; $display("FAIL err_counts: rd=%0d wr=%0d want %0d %0d", rd_count, wr_count, exp_rd, exp_wr); end
        drive(1'b1, 1'b0, 32'h10, 32'h0); exp_rd++;
        checks++; if (ram_word !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_mem_word4: got %h want deadbeef", ram_word); end
        drive(1'b1, 1'b0, 32'h0, 32'h0); exp_rd++;
        checks++; if (ram_word !== 32'hCAFE_F00D) begin errors++; $display("FAIL err_mem_word0: got %h want cafef00d", ram_word); end
        idle_cycles(3);
        checks++; if ({err_align, err_range} !== 2'b11) begin errors++; $display("FAIL err_sticky: got %b want 11", {err_align, err_range}); end
    endtask

    task automatic test_saturation();
        int n;
        pulse_rst(2);
        wait_ready(n);
        checks++; if (n !== 256 || s_ready !== 1'b1) begin errors++; $display("FAIL sat_init: cycles=%0d ready=%b want 256 1", n, s_ready); end
        for (int i = 0; i < 15; i++) begin drive(1'b1, 1'b0, 32'h3FC, 32'h0); exp_rd++; end
        idle_cycles(1);
        checks++; if (s_rd_count !== 4'd15) begin errors++; $display("FAIL sat_at_max: got %0d want 15", s_rd_count); end
        for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 32'h3FC, 32'h0); exp_rd++; end
        idle_cycles(1);
        checks++; if (s_rd_count !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", s_rd_count); end
        checks++; if (s_wr_count !== 4'd0) begin errors++; $display("FAIL sat_wr: got %0d want 0", s_wr_count); end
        checks++; if (rd_count !== 16'(exp_rd)) begin errors++; $display("FAIL sat_wide_rdcnt: got %0d want %0d", rd_count, exp_rd); end
    endtask

    task automatic test_init_access();
        int n;
        logic [31:0] adrs [4];
        adrs[0] = 32'h0; adrs[1] = 32'h10; adrs[2] = 32'h20; adrs[3] = 32'h3FC;
        // Store to an already-cleared word while INIT is still running.
        pulse_rst(1);
        idle_cycles(20);
        drive(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF);
        checks++; if (ram_word !== 32'h0 || ready !== 1'b0) begin errors++; $display("FAIL init_req: word=%h ready=%b want 0 0", ram_word, ready); end
        drive(1'b1, 1'b0, 32'h413, 32'h0);
        idle_cycles(1);
        wait_ready(n);
        checks++; if ({err_align, err_range} !== 2'b00) begin errors++; $display("FAIL init_no_err: got %b want 00", {err_align, err_range}); end
        checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin errors++; $display("FAIL init_no_count: rd=%0d wr=%0d want 0 0", rd_count, wr_count); end
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        checks++; if (ram_word !== 32'h0) begin errors++; $display("FAIL init_store_ignored: got %h want 00000000", ram_word); end
        // Dirty memory in RUN, then reset and restart INIT part-way through.
        drive(1'b0, 1'b1, 32'h3FC, 32'h1234_5678);
        drive(1'b0, 1'b1, 32'h20, 32'h8765_4321);
        pulse_rst(1);
        idle_cycles(50);
        pulse_rst(1);
        wait_ready(n);
        checks++; if (n !== 256) begin errors++; $display("FAIL init_restart_len: got %0d cycles want 256", n); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, adrs[i], 32'h0);
            checks++; if (ram_word !== 32'h0) begin errors++; $display("FAIL init_clear_%0h: got %h want 00000000", adrs[i], ram_word); end
        end
        idle_cycles(1);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_saturation();
        test_init_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
